// File: rtl/dvs_ravens_pkg.sv
// dvs_ravens_pkg
//  Shared constants and types for the DVS event pipeline.
//  CLK_PERIOD_NS  system clock period in ns
//  EVENT_BITS     width of one event word on the event-FIFO write port
//  event_t        one event word
//  arb_state_t    states of the event-FIFO bus arbiter
package dvs_ravens_pkg;

  localparam int CLK_PERIOD_NS = 10;
  localparam int EVENT_BITS    = 32;

  typedef logic [EVENT_BITS-1:0] event_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dvs_fifo_bus_arbiter_rr_priority_select.sv
// rr_priority_select
//  Combinational round-robin pick: returns the first asserted request found
//  when scanning rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ.
//  req     in   NUM_REQ          request vector
//  rr_ptr  in   $clog2(NUM_REQ)  index with highest priority (< NUM_REQ)
//  valid   out  1                at least one request asserted
//  sel     out  $clog2(NUM_REQ)  index of the chosen requester
module rr_priority_select #(
  parameter int NUM_REQ = 2,
  parameter int OWN_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [OWN_W-1:0]   sel
);

  int unsigned idx;

  // Wrap by compare-and-subtract so non-power-of-two NUM_REQ scans correctly.
  always_comb begin
    valid = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!valid && req[idx]) begin
        valid = 1'b1;
        sel   = idx[OWN_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dvs_fifo_bus_arbiter.sv
// dvs_fifo_bus_arbiter
//  Shares the single event-FIFO write port between NUM_REQ producers.
//  Round-robin grant, held until the owner drops its request, followed by one
//  dead RELEASE cycle. The owner's strobe and event word are muxed onto the
//  FIFO; strobes blocked by fifo_full are counted. A watchdog flags grants held
//  longer than MAX_HOLD_CYCLES without revoking them.
//  clk           in   1                     system clock
//  rst_n         in   1                     asynchronous active-low reset
//  fifo_req      in   NUM_REQ               per-requester bus request
//  fifo_wr_en    in   NUM_REQ               per-requester write strobe
//  fifo_event    in   NUM_REQ x EVENT_BITS  per-requester event word
//  fifo_full     in   1                     downstream FIFO full
//  fifo_grant    out  NUM_REQ               one-hot grant, registered
//  wr_en         out  1                     FIFO write enable
//  wdata         out  EVENT_BITS            FIFO write data (0 when no grant)
//  drop_cnt      out  DROP_CNT_BITS         blocked owner writes, saturating
//  hold_timeout  out  1                     sticky grant-hold watchdog flag
module dvs_fifo_bus_arbiter
  import dvs_ravens_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int DROP_CNT_BITS   = 16,
  parameter int MAX_HOLD_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       fifo_req,
  input  logic [NUM_REQ-1:0]       fifo_wr_en,
  input  logic [EVENT_BITS-1:0]    fifo_event [NUM_REQ],
  input  logic                     fifo_full,
  output logic [NUM_REQ-1:0]       fifo_grant,
  output logic                     wr_en,
  output logic [EVENT_BITS-1:0]    wdata,
  output logic [DROP_CNT_BITS-1:0] drop_cnt,
  output logic                     hold_timeout
);

  localparam int OWN_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD_CYCLES + 1);

  localparam logic [1:0] S_IDLE    = ARB_IDLE;
  localparam logic [1:0] S_GRANT   = ARB_GRANT;
  localparam logic [1:0] S_RELEASE = ARB_RELEASE;

  localparam logic [OWN_W-1:0]  LAST_REQ = OWN_W'(NUM_REQ - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD_CYCLES);

  logic [1:0]       state;
  logic [OWN_W-1:0] owner;
  logic [OWN_W-1:0] rr_ptr;
  logic             sel_valid;
  logic [OWN_W-1:0] sel;
  logic [HOLD_W-1:0] hold_cnt;
  logic             owner_strobe;
  event_t           owner_event;

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_rr_select (
    .req    (fifo_req),
    .rr_ptr (rr_ptr),
    .valid  (sel_valid),
    .sel    (sel)
  );

  // Arbitration FSM. Other requests are ignored while a grant is held; the
  // pointer moves past the releasing owner so the next pick is fair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      fifo_grant <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_valid) begin
            fifo_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
            owner      <= sel;
            state      <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!fifo_req[owner]) begin
            fifo_grant <= '0;
            rr_ptr     <= (owner == LAST_REQ) ? '0 : owner + OWN_W'(1);
            state      <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          fifo_grant <= '0;
        end
      endcase
    end
  end

  assign owner_strobe = fifo_wr_en[owner] & fifo_grant[owner];
  assign owner_event  = fifo_event[owner];

  assign wr_en = owner_strobe & ~fifo_full;
  assign wdata = (|fifo_grant) ? owner_event : '0;

  // Owner strobes that hit a full FIFO are lost; count them, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (owner_strobe && fifo_full && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_CNT_BITS'(1);
    end
  end

  // Watchdog: counts edges spent in GRANT; once the count has reached the
  // limit the flag is set and stays set until reset. The grant is untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt     <= '0;
      hold_timeout <= 1'b0;
    end else if (state == S_GRANT) begin
      if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end else begin
        hold_timeout <= 1'b1;
      end
    end else begin
      hold_cnt <= '0;
    end
  end

endmodule
